// File: rtl/rnm_pkg.sv
// Rename-path constants and the {vld, preg} release-entry layout,
// shared by the free list and the translation unit.
package rnm_pkg;

  localparam int unsigned PREG_NUM  = 64;
  localparam int unsigned PREG_BITS = 6;
  localparam int unsigned ARCH_REGS = 16;
  localparam int unsigned ALC_PORTS = 4;
  localparam int unsigned REL_PORTS = 4;
  localparam int unsigned CNT_BITS  = 7;
  localparam int unsigned REL_W     = PREG_BITS + 1;
  localparam int unsigned FREE_INIT = PREG_NUM - ARCH_REGS;

  typedef logic [PREG_BITS-1:0] preg_t;

  typedef struct packed {
    logic  vld;
    preg_t preg;
  } rel_ent_t;

endpackage

// File: rtl/fre_lst_if.sv
// Rename-side bundle of the free list: allocation grants, releases,
// checkpoint controls and status.
interface fre_lst_if;
  import rnm_pkg::*;

  logic [ALC_PORTS-1:0]           alc_req;
  logic [ALC_PORTS*PREG_BITS-1:0] alc_preg_flat;
  logic [ALC_PORTS-1:0]           alc_vld;
  logic                           alc_stl;
  logic [REL_PORTS*REL_W-1:0]     rel_flat;
  logic                           chk_sav;
  logic                           chk_rcv;
  logic [CNT_BITS-1:0]            fre_cnt;
  logic                           ovf_err;

  modport master (
    output alc_req, rel_flat, chk_sav, chk_rcv,
    input  alc_preg_flat, alc_vld, alc_stl, fre_cnt, ovf_err
  );

  modport slave (
    input  alc_req, rel_flat, chk_sav, chk_rcv,
    output alc_preg_flat, alc_vld, alc_stl, fre_cnt, ovf_err
  );

endinterface

// File: rtl/pop_pfx.sv
// 4-bit population count plus exclusive prefix sums, used to compact
// sparse per-port requests onto consecutive FIFO slots.
module pop_pfx (
  input  logic [3:0]      vec,
  output logic [2:0]      total,
  output logic [3:0][1:0] pfx
);

  logic [2:0] run;

  always_comb begin
    run = '0;
    pfx = '0;
    for (int i = 0; i < 4; i++) begin
      pfx[i] = run[1:0];
      run    = run + {2'b00, vec[i]};
    end
    total = run;
  end

endmodule

// File: rtl/fre_lst.sv
// Physical-register free list: circular FIFO of unmapped pregs with
// 4-wide compacted allocate/release and a one-deep head checkpoint.
module fre_lst
  import rnm_pkg::*;
(
  input logic      clk,
  input logic      rst_n,
  fre_lst_if.slave bus
);

  preg_t               mem [PREG_NUM];
  preg_t               hed_q, hed_d;
  preg_t               tal_q, tal_d;
  preg_t               chk_hed_q, chk_hed_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic [2:0]           n_alc, n_rel, n_pop;
  logic [3:0][1:0]      alc_pfx, rel_pfx;
  logic [REL_PORTS-1:0] rel_vld;
  rel_ent_t             rel_ent [REL_PORTS];
  logic                 stall;
  preg_t                rcv_dist;
  logic [CNT_BITS+1:0]  cnt_sum;

  pop_pfx u_alc_pfx (
    .vec   (bus.alc_req),
    .total (n_alc),
    .pfx   (alc_pfx)
  );

  pop_pfx u_rel_pfx (
    .vec   (rel_vld),
    .total (n_rel),
    .pfx   (rel_pfx)
  );

  always_comb begin
    for (int i = 0; i < REL_PORTS; i++) begin
      rel_ent[i] = rel_ent_t'(bus.rel_flat[i*REL_W +: REL_W]);
      rel_vld[i] = rel_ent[i].vld;
    end
  end

  // All-or-nothing grant; a recovery cycle never allocates.
  always_comb begin
    stall = ({{(CNT_BITS-3){1'b0}}, n_alc} > cnt_q) | bus.chk_rcv;
    n_pop = stall ? 3'd0 : n_alc;
    for (int i = 0; i < ALC_PORTS; i++) begin
      bus.alc_preg_flat[i*PREG_BITS +: PREG_BITS] = mem[hed_q + preg_t'(alc_pfx[i])];
    end
    bus.alc_vld = stall ? '0 : bus.alc_req;
  end

  assign bus.alc_stl = stall;
  assign bus.fre_cnt = cnt_q;
  assign bus.ovf_err = ovf_q;

  always_comb begin
    rcv_dist = hed_q - chk_hed_q;
    tal_d    = tal_q + preg_t'(n_rel);
    if (bus.chk_rcv) begin
      hed_d   = chk_hed_q;
      cnt_sum = {2'b00, cnt_q} + (CNT_BITS+2)'(rcv_dist) + (CNT_BITS+2)'(n_rel);
    end else begin
      hed_d   = hed_q + preg_t'(n_pop);
      cnt_sum = {2'b00, cnt_q} - (CNT_BITS+2)'(n_pop) + (CNT_BITS+2)'(n_rel);
    end
    cnt_d = cnt_sum[CNT_BITS-1:0];
    ovf_d = ovf_q | (cnt_sum > (CNT_BITS+2)'(FREE_INIT));
    // Snapshot taken after this cycle's pops; recovery keeps the old one.
    if (bus.chk_rcv)      chk_hed_d = chk_hed_q;
    else if (bus.chk_sav) chk_hed_d = hed_d;
    else                  chk_hed_d = chk_hed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hed_q     <= '0;
      tal_q     <= preg_t'(FREE_INIT);
      chk_hed_q <= '0;
      cnt_q     <= CNT_BITS'(FREE_INIT);
      ovf_q     <= 1'b0;
    end else begin
      hed_q     <= hed_d;
      tal_q     <= tal_d;
      chk_hed_q <= chk_hed_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Slots past the initial free set wrap to the mapped pregs; they are never read before rewrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PREG_NUM; k++) begin
        mem[k] <= preg_t'(ARCH_REGS + k);
      end
    end else begin
      for (int i = 0; i < REL_PORTS; i++) begin
        if (rel_vld[i]) mem[tal_q + preg_t'(rel_pfx[i])] <= rel_ent[i].preg;
      end
    end
  end

endmodule

// File: tb/tb_fre_lst.sv
// Directed bench for fre_lst: vector table for single-cycle behaviour plus
// hand sequences for drain/stall, checkpoint and overflow.
module tb_fre_lst;
  import rnm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fre_lst_if bus ();

  fre_lst dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [27:0] rel;
    logic        stl;
    logic [3:0]  vld;
    int          p0, p1, p2, p3;
    int          cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic logic [6:0] ent(input int p);
    return {1'b1, 6'(p)};
  endfunction

  function automatic logic [27:0] rels(input logic [6:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic drive(input logic [3:0] req, input logic [27:0] rel,
                       input logic sav, input logic rcv);
    @(negedge clk);
    bus.alc_req  = req;
    bus.rel_flat = rel;
    bus.chk_sav  = sav;
    bus.chk_rcv  = rcv;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n        = 1'b0;
    bus.alc_req  = '0;
    bus.rel_flat = '0;
    bus.chk_sav  = 1'b0;
    bus.chk_rcv  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic grant(input string name, input logic stl, input logic [3:0] vld,
                       input int p0, input int p1, input int p2, input int p3);
    int p [4];
    p = '{p0, p1, p2, p3};
    chk({name, ".stl"}, 32'(bus.alc_stl), 32'(stl));
    chk({name, ".vld"}, 32'(bus.alc_vld), 32'(vld));
    for (int i = 0; i < 4; i++) begin
      if (vld[i]) chk($sformatf("%s.p%0d", name, i), 32'(bus.alc_preg_flat[i*6 +: 6]), p[i]);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'b1111, 28'd0, 1'b0, 4'b1111, 16, 17, 18, 19, 44};
    vecs[1] = '{1'b1, 4'b1010, 28'd0, 1'b0, 4'b1010,  0, 16,  0, 17, 46};
    vecs[2] = '{1'b1, 4'b0000, 28'd0, 1'b0, 4'b0000,  0,  0,  0,  0, 48};
    vecs[3] = '{1'b0, 4'b0001, 28'd0, 1'b0, 4'b0001, 16,  0,  0,  0, 47};
    vecs[4] = '{1'b0, 4'b0110, 28'd0, 1'b0, 4'b0110,  0, 17, 18,  0, 45};
    vecs[5] = '{1'b0, 4'b0000, rels(7'd0, 7'd0, 7'd0, ent(40)),
                1'b0, 4'b0000, 0, 0, 0, 0, 46};
    vecs[6] = '{1'b0, 4'b1001, 28'd0, 1'b0, 4'b1001, 19,  0,  0, 20, 44};
    vecs[7] = '{1'b0, 4'b0100, rels(ent(7), {1'b0, 6'd33}, ent(8), 7'd0),
                1'b0, 4'b0100, 0, 0, 21, 0, 45};
    vecs[8] = '{1'b0, 4'b1111, 28'd0, 1'b0, 4'b1111, 22, 23, 24, 25, 41};

    do_reset;
    drive(4'b0000, 28'd0, 1'b0, 1'b0);
    chk("rst.cnt", 32'(bus.fre_cnt), 48);
    chk("rst.ovf", 32'(bus.ovf_err), 0);
    grant("rst", 1'b0, 4'b0000, 0, 0, 0, 0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst) do_reset;
      drive(vecs[i].req, vecs[i].rel, 1'b0, 1'b0);
      grant($sformatf("vec%0d", i), vecs[i].stl, vecs[i].vld,
            vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3);
      tick;
      chk($sformatf("vec%0d.cnt", i), 32'(bus.fre_cnt), vecs[i].cnt);
    end

    // Drain to two entries, stall, then mixed alloc/release, then no bypass.
    do_reset;
    repeat (11) begin
      drive(4'b1111, 28'd0, 1'b0, 1'b0);
      tick;
    end
    drive(4'b0011, 28'd0, 1'b0, 1'b0);
    tick;
    chk("drain.cnt", 32'(bus.fre_cnt), 2);
    drive(4'b0111, 28'd0, 1'b0, 1'b0);
    grant("drain.stall", 1'b1, 4'b0000, 0, 0, 0, 0);
    tick;
    chk("drain.stall.cnt", 32'(bus.fre_cnt), 2);
    drive(4'b0011, rels(ent(5), 7'd0, ent(9), 7'd0), 1'b0, 1'b0);
    grant("drain.mix", 1'b0, 4'b0011, 62, 63, 0, 0);
    tick;
    chk("drain.mix.cnt", 32'(bus.fre_cnt), 2);
    drive(4'b0001, 28'd0, 1'b0, 1'b0);
    grant("drain.rel5", 1'b0, 4'b0001, 5, 0, 0, 0);
    tick;
    drive(4'b0001, 28'd0, 1'b0, 1'b0);
    grant("drain.rel9", 1'b0, 4'b0001, 9, 0, 0, 0);
    tick;
    chk("drain.empty.cnt", 32'(bus.fre_cnt), 0);
    drive(4'b0001, rels(ent(11), 7'd0, 7'd0, 7'd0), 1'b0, 1'b0);
    grant("nobypass", 1'b1, 4'b0000, 0, 0, 0, 0);
    tick;
    chk("nobypass.cnt", 32'(bus.fre_cnt), 1);
    drive(4'b0001, 28'd0, 1'b0, 1'b0);
    grant("nobypass.next", 1'b0, 4'b0001, 11, 0, 0, 0);
    tick;

    // Save at hed=4, allocate 8, recover with one release.
    do_reset;
    drive(4'b1111, 28'd0, 1'b0, 1'b0);
    tick;
    drive(4'b0000, 28'd0, 1'b1, 1'b0);
    tick;
    drive(4'b1111, 28'd0, 1'b0, 1'b0);
    grant("chk.a0", 1'b0, 4'b1111, 20, 21, 22, 23);
    tick;
    drive(4'b1111, 28'd0, 1'b0, 1'b0);
    grant("chk.a1", 1'b0, 4'b1111, 24, 25, 26, 27);
    tick;
    chk("chk.pre.cnt", 32'(bus.fre_cnt), 36);
    drive(4'b1111, rels(ent(2), 7'd0, 7'd0, 7'd0), 1'b0, 1'b1);
    grant("chk.rcv", 1'b1, 4'b0000, 0, 0, 0, 0);
    tick;
    chk("chk.rcv.cnt", 32'(bus.fre_cnt), 45);
    drive(4'b1111, 28'd0, 1'b0, 1'b0);
    grant("chk.replay", 1'b0, 4'b1111, 20, 21, 22, 23);
    tick;
    chk("chk.replay.cnt", 32'(bus.fre_cnt), 41);

    // Snapshot taken with pops in the same cycle includes those pops.
    do_reset;
    drive(4'b1111, 28'd0, 1'b1, 1'b0);
    tick;
    drive(4'b1111, 28'd0, 1'b0, 1'b0);
    tick;
    drive(4'b0000, 28'd0, 1'b0, 1'b1);
    tick;
    chk("savpop.cnt", 32'(bus.fre_cnt), 44);
    drive(4'b0001, 28'd0, 1'b0, 1'b0);
    grant("savpop", 1'b0, 4'b0001, 20, 0, 0, 0);
    tick;

    // Recovery without a save returns to the reset snapshot.
    do_reset;
    drive(4'b1111, 28'd0, 1'b0, 1'b0);
    tick;
    drive(4'b0000, 28'd0, 1'b0, 1'b1);
    tick;
    chk("nosave.cnt", 32'(bus.fre_cnt), 48);
    chk("nosave.ovf", 32'(bus.ovf_err), 0);
    drive(4'b0001, 28'd0, 1'b0, 1'b0);
    grant("nosave", 1'b0, 4'b0001, 16, 0, 0, 0);
    tick;

    // Seventeen surplus releases at a full list set the sticky error.
    do_reset;
    for (int c = 0; c < 4; c++) begin
      drive(4'b0000, rels(ent(4*c), ent(4*c+1), ent(4*c+2), ent(4*c+3)), 1'b0, 1'b0);
      tick;
    end
    drive(4'b0000, rels(ent(16), 7'd0, 7'd0, 7'd0), 1'b0, 1'b0);
    tick;
    chk("ovf.set", 32'(bus.ovf_err), 1);
    chk("ovf.cnt", 32'(bus.fre_cnt), 65);
    drive(4'b0000, 28'd0, 1'b0, 1'b0);
    tick;
    tick;
    chk("ovf.sticky", 32'(bus.ovf_err), 1);
    do_reset;
    #2;
    chk("ovf.clear", 32'(bus.ovf_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
